// File: rtl/csa_wide_add_sequencer.sv
// csa_wide_add_sequencer
//   Feeds a single 4-bit carry_select_adder one chunk per cycle, LSB chunk
//   first, to add two WIDTH-bit operands. The carry out of each chunk is
//   registered and becomes the carry in of the next chunk. The assembled sum
//   and the final carry are presented downstream over a valid/ready handshake.
//
// Ports
//   clk        in   1      clock; all state changes on the rising edge
//   rst        in   1      synchronous active-high reset
//   in_valid   in   1      operand pair present
//   in_ready   out  1      sequencer can accept an operand pair
//   in_a       in   WIDTH  operand A
//   in_b       in   WIDTH  operand B
//   in_cin     in   1      carry into the LSB chunk
//   out_valid  out  1      result present
//   out_ready  in   1      downstream accepts the result
//   out_sum    out  WIDTH  (in_a + in_b + in_cin) mod 2^WIDTH
//   out_cout   out  1      carry out of the MSB chunk
//   busy       out  1      high while an operation is in flight or waiting

// carry_select_adder
//   4-bit adder. The low pair of bits ripples; the high pair is computed for
//   both possible carries and the low pair's carry selects between them.
//
// Ports
//   a, b   in   4   addends
//   cin    in   1   carry in
//   sum    out  4   a + b + cin, low 4 bits
//   cout   out  1   carry out
module carry_select_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [2:0] lo;
  logic [2:0] hi0;
  logic [2:0] hi1;

  assign lo  = {1'b0, a[1:0]} + {1'b0, b[1:0]} + {2'b00, cin};
  assign hi0 = {1'b0, a[3:2]} + {1'b0, b[3:2]};
  // Largest value is 3 + 3 + 1 = 7, so three bits never overflow.
  assign hi1 = hi0 + 3'd1;

  assign sum  = {(lo[2] ? hi1[1:0] : hi0[1:0]), lo[1:0]};
  assign cout = lo[2] ? hi1[2] : hi0[2];

endmodule

module csa_wide_add_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             busy
);

  localparam int NCHUNK = WIDTH / 4;
  // A single-chunk build still needs a 1-bit index.
  localparam int IDXW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    DONE
  } state_t;

  state_t           state;
  logic [IDXW-1:0]  idx;
  logic             carry;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] result;

  logic [3:0]       chunk_a;
  logic [3:0]       chunk_b;
  logic [3:0]       add_sum;
  logic             add_cout;
  logic [WIDTH-1:0] result_next;

  // Select the current chunk of each operand and splice the adder's sum
  // into the running result. result_next is what the result register holds
  // after this edge, which lets the last ADD edge load out_sum directly.
  always_comb begin
    chunk_a     = '0;
    chunk_b     = '0;
    result_next = result;
    for (int i = 0; i < NCHUNK; i++) begin
      if (idx == IDXW'(i)) begin
        chunk_a                = a_reg[4*i +: 4];
        chunk_b                = b_reg[4*i +: 4];
        result_next[4*i +: 4]  = add_sum;
      end
    end
  end

  carry_select_adder u_csa (
    .a    (chunk_a),
    .b    (chunk_b),
    .cin  (carry),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Control FSM and all registered outputs. in_ready, out_valid and busy are
  // held in flops so no input can reach an output combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      carry     <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      result    <= '0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_reg    <= in_a;
            b_reg    <= in_b;
            carry    <= in_cin;
            idx      <= '0;
            result   <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= ADD;
          end
        end
        ADD: begin
          result <= result_next;
          carry  <= add_cout;
          if (idx == LAST_IDX) begin
            out_sum   <= result_next;
            out_cout  <= add_cout;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx + IDXW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
